// File: rtl/seg_display.sv
// seg_display: memory-mapped 8-digit common-anode seven-segment controller.
// The CPU writes LOW (0x0), HIGH (0x2) and CTRL (0x4) over the peripheral bus.
// A scan engine time-multiplexes the digits and blanks the start of each slot.
module seg_display #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Select,
  input  logic        Write_enable,
  input  logic        Read_enable,
  input  logic [3:0]  Address,
  input  logic [15:0] Write_data,
  output logic [15:0] Read_data_out,
  output logic [7:0]  Digit_sel,
  output logic [7:0]  Segments
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  // Bus-visible registers
  logic [15:0] low_q, high_q, ctrl_q;
  logic [15:0] rd_q, rd_d;

  // Scan engine state and registered outputs
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    digit_sel_q, digit_sel_d;
  logic [7:0]    segments_q, segments_d;

  logic [31:0] digits;
  logic [3:0]  nibble;
  logic [7:0]  en_mask, dp_mask;

  // Active-low g..a pattern for one hex digit
  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign digits  = {high_q, low_q};
  assign en_mask = ctrl_q[7:0];
  assign dp_mask = ctrl_q[15:8];

  // Next-state for slot counter, digit index and display outputs
  always_comb begin
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
      idx_d = idx_q;
    end

    nibble      = digits[{idx_d, 2'b00} +: 4];
    segments_d  = segments_q;
    digit_sel_d = digit_sel_q;

    // Slot entry: new pattern with all digits off so segments never change while lit
    if (cnt_d == '0) begin
      segments_d  = {~dp_mask[idx_d], hex7seg(nibble)};
      digit_sel_d = '1;
    end
    // End of blanking; evaluated after slot entry so BLANK_CYCLES=0 lights at entry
    if (cnt_d == CNT_BLANK) begin
      digit_sel_d = en_mask[idx_d] ? ~(8'd1 << idx_d) : '1;
    end
  end

  // Read-back mux; registers sampled before any same-edge write lands
  always_comb begin
    rd_d = rd_q;
    if (Select && Read_enable) begin
      case (Address)
        4'h0:    rd_d = low_q;
        4'h2:    rd_d = high_q;
        4'h4:    rd_d = ctrl_q;
        default: rd_d = '0;
      endcase
    end
  end

  // Register file, read-back and scan state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      low_q       <= '0;
      high_q      <= '0;
      ctrl_q      <= '0;
      rd_q        <= '0;
      cnt_q       <= CNT_LAST;
      idx_q       <= 3'd7;
      digit_sel_q <= '1;
      segments_q  <= '1;
    end else begin
      if (Select && Write_enable) begin
        case (Address)
          4'h0:    low_q  <= Write_data;
          4'h2:    high_q <= Write_data;
          4'h4:    ctrl_q <= Write_data;
          default: ;
        endcase
      end
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      digit_sel_q <= digit_sel_d;
      segments_q  <= segments_d;
    end
  end

  assign Read_data_out = rd_q;
  assign Digit_sel     = digit_sel_q;
  assign Segments      = segments_q;

endmodule

// File: tb/tb_seg_display.sv
// tb_seg_display: directed checks of seg_display with an 8-cycle slot and 2-cycle blanking.
module tb_seg_display;

  localparam int SD = 8;

  logic        clock;
  logic        reset;
  logic        Select;
  logic        Write_enable;
  logic        Read_enable;
  logic [3:0]  Address;
  logic [15:0] Write_data;
  logic [15:0] Read_data_out;
  logic [7:0]  Digit_sel;
  logic [7:0]  Segments;

  int compared   = 0;
  int mismatched = 0;
  int n;  // edges since reset release; bench-side scan position

  seg_display #(.SCAN_DIV(SD), .BLANK_CYCLES(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .Select       (Select),
    .Write_enable (Write_enable),
    .Read_enable  (Read_enable),
    .Address      (Address),
    .Write_data   (Write_data),
    .Read_data_out(Read_data_out),
    .Digit_sel    (Digit_sel),
    .Segments     (Segments)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  // One bus cycle: drive after a falling edge, sampled on the next rising edge
  task automatic bus(input logic sel, input logic we, input logic re,
                     input logic [3:0] a, input logic [15:0] d);
    Select = sel; Write_enable = we; Read_enable = re; Address = a; Write_data = d;
    @(negedge clock);
    Select = 1'b0; Write_enable = 1'b0; Read_enable = 1'b0; Address = 4'h0; Write_data = 16'h0;
  endtask

  // Advance to the falling edge where the bench model is at slot s, cycle c
  task automatic wait_pos(input int s, input int c);
    int  tries;
    bit  hit;
    tries = 0;
    hit   = 1'b0;
    while (!hit && tries < 200) begin
      @(negedge clock);
      tries++;
      hit = (n > 0) && ((n - 1) % SD == c) && (((n - 1) / SD) % 8 == s);
    end
    if (!hit) begin
      compared++; mismatched++;
      $display("FAIL wait_pos: timeout reaching slot %0d cycle %0d", s, c);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    compared++;
    if (Segments !== 8'hC0) begin mismatched++; $display("FAIL reset_first_seg: got %h want c0", Segments); end
    compared++;
    if (Digit_sel !== 8'hFF) begin mismatched++; $display("FAIL reset_first_sel: got %h want ff", Digit_sel); end
    bus(1, 1, 0, 4'h4, 16'h1234);
    bus(1, 0, 1, 4'h4, 16'h0000);
    compared++;
    if (Read_data_out !== 16'h1234) begin mismatched++; $display("FAIL reset_pre_read: got %h want 1234", Read_data_out); end
    wait_pos(2, 3);
    compared++;
    if (Digit_sel !== 8'hFB) begin mismatched++; $display("FAIL reset_pre_sel: got %h want fb", Digit_sel); end
    #2 reset = 1'b1;
    #1;
    compared++;
    if (Digit_sel !== 8'hFF) begin mismatched++; $display("FAIL reset_async_sel: got %h want ff", Digit_sel); end
    compared++;
    if (Segments !== 8'hFF) begin mismatched++; $display("FAIL reset_async_seg: got %h want ff", Segments); end
    compared++;
    if (Read_data_out !== 16'h0000) begin mismatched++; $display("FAIL reset_async_rd: got %h want 0000", Read_data_out); end
    @(negedge clock);
    reset = 1'b0;
    bus(1, 0, 1, 4'h4, 16'h0000);
    compared++;
    if (Read_data_out !== 16'h0000) begin mismatched++; $display("FAIL reset_ctrl_cleared: got %h want 0000", Read_data_out); end
    compared++;
    if (Segments !== 8'hC0 || Digit_sel !== 8'hFF)
      begin mismatched++; $display("FAIL reset_slot0_entry: got seg %h sel %h want c0 ff", Segments, Digit_sel); end
  endtask

  task automatic test_single_digit;
    logic [7:0] es, ed;
    int s, c;
    bus(1, 1, 0, 4'h0, 16'h0001);
    bus(1, 1, 0, 4'h4, 16'h0001);
    wait_pos(0, 0);
    for (int i = 0; i < 8 * SD; i++) begin
      if (i > 0) @(negedge clock);
      s  = i / SD;
      c  = i % SD;
      ed = (s == 0 && c >= 2) ? 8'hFE : 8'hFF;
      es = (s == 0) ? 8'hF9 : 8'hC0;
      compared++;
      if (Digit_sel !== ed) begin mismatched++; $display("FAIL single_sel s%0d c%0d: got %h want %h", s, c, Digit_sel, ed); end
      compared++;
      if (Segments !== es) begin mismatched++; $display("FAIL single_seg s%0d c%0d: got %h want %h", s, c, Segments, es); end
    end
  endtask

  task automatic test_all_digits;
    logic [7:0] tbl [8];
    logic [7:0] ed;
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'hC6, 8'hA1, 8'h86, 8'h0E};
    bus(1, 1, 0, 4'h0, 16'h3210);
    bus(1, 1, 0, 4'h2, 16'hFEDC);
    bus(1, 1, 0, 4'h4, 16'h80FF);
    for (int k = 0; k < 8; k++) begin
      wait_pos(k, 1);
      compared++;
      if (Digit_sel !== 8'hFF) begin mismatched++; $display("FAIL all_blank d%0d: got %h want ff", k, Digit_sel); end
      compared++;
      if (Segments !== tbl[k]) begin mismatched++; $display("FAIL all_seg d%0d: got %h want %h", k, Segments, tbl[k]); end
      @(negedge clock);
      ed = 8'hFF;
      ed[k] = 1'b0;
      compared++;
      if (Digit_sel !== ed) begin mismatched++; $display("FAIL all_sel d%0d: got %h want %h", k, Digit_sel, ed); end
    end
  endtask

  task automatic test_mid_slot_write;
    wait_pos(3, 4);
    compared++;
    if (Segments !== 8'hB0 || Digit_sel !== 8'hF7)
      begin mismatched++; $display("FAIL mid_before: got seg %h sel %h want b0 f7", Segments, Digit_sel); end
    bus(1, 1, 0, 4'h0, 16'h8000);
    compared++;
    if (Segments !== 8'hB0) begin mismatched++; $display("FAIL mid_after_write: got %h want b0", Segments); end
    wait_pos(3, 7);
    compared++;
    if (Segments !== 8'hB0) begin mismatched++; $display("FAIL mid_slot_end: got %h want b0", Segments); end
    wait_pos(3, 0);
    compared++;
    if (Segments !== 8'h80 || Digit_sel !== 8'hFF)
      begin mismatched++; $display("FAIL mid_next_entry: got seg %h sel %h want 80 ff", Segments, Digit_sel); end
    repeat (2) @(negedge clock);
    compared++;
    if (Segments !== 8'h80 || Digit_sel !== 8'hF7)
      begin mismatched++; $display("FAIL mid_next_lit: got seg %h sel %h want 80 f7", Segments, Digit_sel); end
  endtask

  task automatic test_wrap_around;
    wait_pos(7, 7);
    compared++;
    if (Segments !== 8'h0E || Digit_sel !== 8'h7F)
      begin mismatched++; $display("FAIL wrap_last: got seg %h sel %h want 0e 7f", Segments, Digit_sel); end
    @(negedge clock);
    compared++;
    if (Segments !== 8'hC0 || Digit_sel !== 8'hFF)
      begin mismatched++; $display("FAIL wrap_entry: got seg %h sel %h want c0 ff", Segments, Digit_sel); end
    repeat (2) @(negedge clock);
    compared++;
    if (Digit_sel !== 8'hFE) begin mismatched++; $display("FAIL wrap_slot0_lit: got %h want fe", Digit_sel); end
    wait_pos(1, 2);
    compared++;
    if (Segments !== 8'hC0 || Digit_sel !== 8'hFD)
      begin mismatched++; $display("FAIL wrap_slot1: got seg %h sel %h want c0 fd", Segments, Digit_sel); end
  endtask

  task automatic test_readback;
    bus(1, 1, 0, 4'h4, 16'hA55A);
    bus(1, 0, 1, 4'h4, 16'h0000);
    compared++;
    if (Read_data_out !== 16'hA55A) begin mismatched++; $display("FAIL rd_ctrl: got %h want a55a", Read_data_out); end
    bus(1, 0, 1, 4'h6, 16'h0000);
    compared++;
    if (Read_data_out !== 16'h0000) begin mismatched++; $display("FAIL rd_unmapped: got %h want 0000", Read_data_out); end
    bus(1, 0, 1, 4'h2, 16'h0000);
    compared++;
    if (Read_data_out !== 16'hFEDC) begin mismatched++; $display("FAIL rd_high: got %h want fedc", Read_data_out); end
    bus(0, 1, 0, 4'h4, 16'h1111);
    compared++;
    if (Read_data_out !== 16'hFEDC) begin mismatched++; $display("FAIL rd_hold: got %h want fedc", Read_data_out); end
    bus(1, 0, 1, 4'h4, 16'h0000);
    compared++;
    if (Read_data_out !== 16'hA55A) begin mismatched++; $display("FAIL rd_unselected_write: got %h want a55a", Read_data_out); end
    bus(0, 0, 1, 4'h2, 16'h0000);
    compared++;
    if (Read_data_out !== 16'hA55A) begin mismatched++; $display("FAIL rd_unselected_read: got %h want a55a", Read_data_out); end
    bus(1, 1, 0, 4'h1, 16'hFFFF);
    bus(1, 0, 1, 4'h0, 16'h0000);
    compared++;
    if (Read_data_out !== 16'h8000) begin mismatched++; $display("FAIL rd_odd_addr_ignored: got %h want 8000", Read_data_out); end
    bus(1, 1, 1, 4'h0, 16'h5555);
    compared++;
    if (Read_data_out !== 16'h8000) begin mismatched++; $display("FAIL rd_same_edge_old: got %h want 8000", Read_data_out); end
    bus(1, 0, 1, 4'h0, 16'h0000);
    compared++;
    if (Read_data_out !== 16'h5555) begin mismatched++; $display("FAIL rd_same_edge_new: got %h want 5555", Read_data_out); end
  endtask

  initial begin
    reset = 1'b1;
    Select = 1'b0; Write_enable = 1'b0; Read_enable = 1'b0;
    Address = 4'h0; Write_data = 16'h0;
    test_reset;
    test_single_digit;
    test_all_digits;
    test_mid_slot_write;
    test_wrap_around;
    test_readback;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
